// File: rtl/dla_acl_ecc_stream_decoder.sv
// Streaming SECDED decoder: two-stage valid/ready pipeline with tag passthrough,
// per-beat error flags, saturating error counters and first-double-error tag capture.

package dla_acl_ecc_pkg;

    function automatic int getParityBitsEccGroup(input int dataBits);
        int p;
        p = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << p) < dataBits + p + 1) p = p + 1;
        end
        return p;
    endfunction

    // Overall parity bit plus Hamming parity plus data.
    function automatic int getEncodedBitsEccGroup(input int dataBits);
        return dataBits + getParityBitsEccGroup(dataBits) + 1;
    endfunction

    function automatic int getNumGroups(input int dataWidth, input int groupSize);
        return (dataWidth + groupSize - 1) / groupSize;
    endfunction

    function automatic int getLastGroupSize(input int dataWidth, input int groupSize);
        return ((dataWidth % groupSize) == 0) ? groupSize : (dataWidth % groupSize);
    endfunction

    function automatic int getEncodedBits(input int dataWidth, input int groupSize);
        return (getNumGroups(dataWidth, groupSize) - 1) * getEncodedBitsEccGroup(groupSize)
             + getEncodedBitsEccGroup(getLastGroupSize(dataWidth, groupSize));
    endfunction

    // Codeword position of data bit j: the j-th index >= 3 that is not a power of two.
    function automatic int getDataPosition(input int j);
        int pos;
        int seen;
        pos  = 0;
        seen = 0;
        for (int i = 3; i < 1024; i++) begin
            if (pos == 0 && (i & (i - 1)) != 0) begin
                if (seen == j) pos = i;
                seen = seen + 1;
            end
        end
        return pos;
    endfunction

endpackage

module dla_acl_ecc_stream_decoder
    import dla_acl_ecc_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ECC_GROUP_SIZE = 32,
    parameter int TAG_WIDTH      = 10,
    parameter int COUNTER_WIDTH  = 16,
    localparam int ENCODED_BITS  = getEncodedBits(DATA_WIDTH, ECC_GROUP_SIZE)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [ENCODED_BITS-1:0]  i_encoded,
    input  logic [TAG_WIDTH-1:0]     i_tag,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [DATA_WIDTH-1:0]    o_data,
    output logic [TAG_WIDTH-1:0]     o_tag,
    output logic                     o_sbe,
    output logic                     o_dbe,
    input  logic                     i_clear,
    output logic [COUNTER_WIDTH-1:0] o_sbe_count,
    output logic [COUNTER_WIDTH-1:0] o_dbe_count,
    output logic                     o_dbe_tag_valid,
    output logic [TAG_WIDTH-1:0]     o_dbe_tag
);

    localparam int NUM_GROUPS = getNumGroups(DATA_WIDTH, ECC_GROUP_SIZE);
    localparam int LAST_GROUP = getLastGroupSize(DATA_WIDTH, ECC_GROUP_SIZE);
    localparam int GROUP_ENC  = getEncodedBitsEccGroup(ECC_GROUP_SIZE);

    logic                     r_s1Valid;
    logic [ENCODED_BITS-1:0]  r_s1Code;
    logic [TAG_WIDTH-1:0]     r_s1Tag;
    logic                     r_s2Valid;
    logic [DATA_WIDTH-1:0]    r_s2Data;
    logic [TAG_WIDTH-1:0]     r_s2Tag;
    logic                     r_s2Sbe;
    logic                     r_s2Dbe;
    logic [COUNTER_WIDTH-1:0] r_sbeCount;
    logic [COUNTER_WIDTH-1:0] r_dbeCount;
    logic                     r_dbeTagValid;
    logic [TAG_WIDTH-1:0]     r_dbeTag;

    logic [DATA_WIDTH-1:0]    w_decData;
    logic [NUM_GROUPS-1:0]    w_grpSbe;
    logic [NUM_GROUPS-1:0]    w_grpDbe;
    logic                     w_beatSbe;
    logic                     w_beatDbe;
    logic                     w_s2Load;
    logic                     w_s1Adv;
    logic                     w_s1Load;
    logic                     w_countSbe;
    logic                     w_countDbe;
    logic                     w_capture;

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
        localparam int GD   = (g == NUM_GROUPS - 1) ? LAST_GROUP : ECC_GROUP_SIZE;
        localparam int GP   = getParityBitsEccGroup(GD);
        localparam int GE   = GD + GP + 1;
        localparam int EOFF = g * GROUP_ENC;
        localparam int DOFF = g * ECC_GROUP_SIZE;

        logic [GE-1:0] w_code;
        logic [GP-1:0] w_syn;
        logic          w_par;
        logic [GD-1:0] w_dat;

        assign w_code = r_s1Code[EOFF +: GE];

        // The syndrome is the XOR of the indices of all set bits.
        always_comb begin
            w_syn = '0;
            w_par = 1'b0;
            for (int i = 0; i < GE; i++) begin
                w_par = w_par ^ w_code[i];
                if (w_code[i]) w_syn = w_syn ^ GP'(i);
            end
        end

        for (genvar j = 0; j < GD; j++) begin : g_bit
            localparam int POS = getDataPosition(j);
            assign w_dat[j] = w_code[POS] ^ (w_par && (w_syn == GP'(POS)));
        end

        assign w_decData[DOFF +: GD] = w_dat;
        assign w_grpSbe[g]           = w_par;
        assign w_grpDbe[g]           = !w_par && (w_syn != '0);
    end

    assign w_beatSbe = |w_grpSbe;
    assign w_beatDbe = |w_grpDbe;

    assign w_s2Load = !r_s2Valid || i_ready;
    assign w_s1Adv  = r_s1Valid && w_s2Load;
    assign w_s1Load = !r_s1Valid || w_s1Adv;
    assign o_ready  = w_s1Load;

    assign w_countSbe = w_s1Adv && w_beatSbe;
    assign w_countDbe = w_s1Adv && w_beatDbe;
    assign w_capture  = w_countDbe && (i_clear || !r_dbeTagValid);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1Valid <= 1'b0;
            r_s1Code  <= '0;
            r_s1Tag   <= '0;
        end else if (w_s1Load) begin
            r_s1Valid <= i_valid;
            if (i_valid) begin
                r_s1Code <= i_encoded;
                r_s1Tag  <= i_tag;
            end
        end
    end

    // Payload registers only move on a load, so they hold steady during a stall.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s2Valid <= 1'b0;
            r_s2Data  <= '0;
            r_s2Tag   <= '0;
            r_s2Sbe   <= 1'b0;
            r_s2Dbe   <= 1'b0;
        end else if (w_s2Load) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2Data <= w_decData;
                r_s2Tag  <= r_s1Tag;
                r_s2Sbe  <= w_beatSbe;
                r_s2Dbe  <= w_beatDbe;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sbeCount <= '0;
            r_dbeCount <= '0;
        end else begin
            if (i_clear)
                r_sbeCount <= w_countSbe ? COUNTER_WIDTH'(1) : '0;
            else if (w_countSbe && (r_sbeCount != '1))
                r_sbeCount <= r_sbeCount + COUNTER_WIDTH'(1);

            if (i_clear)
                r_dbeCount <= w_countDbe ? COUNTER_WIDTH'(1) : '0;
            else if (w_countDbe && (r_dbeCount != '1))
                r_dbeCount <= r_dbeCount + COUNTER_WIDTH'(1);
        end
    end

    // A double error moving in alongside a clear becomes the new first capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dbeTagValid <= 1'b0;
            r_dbeTag      <= '0;
        end else if (w_capture) begin
            r_dbeTagValid <= 1'b1;
            r_dbeTag      <= r_s1Tag;
        end else if (i_clear) begin
            r_dbeTagValid <= 1'b0;
            r_dbeTag      <= '0;
        end
    end

    assign o_valid         = r_s2Valid;
    assign o_data          = r_s2Data;
    assign o_tag           = r_s2Tag;
    assign o_sbe           = r_s2Sbe;
    assign o_dbe           = r_s2Dbe;
    assign o_sbe_count     = r_sbeCount;
    assign o_dbe_count     = r_dbeCount;
    assign o_dbe_tag_valid = r_dbeTagValid;
    assign o_dbe_tag       = r_dbeTag;

endmodule

// File: tb/tb_dla_acl_ecc_stream_decoder.sv
// Directed bench for dla_acl_ecc_stream_decoder: 70-bit data in groups of 32,
// 2-bit counters so saturation is reachable.

module tb_dla_acl_ecc_stream_decoder;

    localparam int DW   = 70;
    localparam int TW   = 10;
    localparam int CW   = 2;
    localparam int ENC  = dla_acl_ecc_pkg::getEncodedBits(70, 32);
    localparam int NVEC = 10;
    localparam int NRAND = 300;

    typedef struct {
        logic [DW-1:0]  data;
        logic [TW-1:0]  tag;
        logic [ENC-1:0] flips;
        logic [DW-1:0]  expData;
        logic           expSbe;
        logic           expDbe;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } beat_t;

    logic           clock;
    logic           reset;
    logic           i_valid;
    logic           o_ready;
    logic [ENC-1:0] i_encoded;
    logic [TW-1:0]  i_tag;
    logic           o_valid;
    logic           i_ready;
    logic [DW-1:0]  o_data;
    logic [TW-1:0]  o_tag;
    logic           o_sbe;
    logic           o_dbe;
    logic           i_clear;
    logic [CW-1:0]  o_sbe_count;
    logic [CW-1:0]  o_dbe_count;
    logic           o_dbe_tag_valid;
    logic [TW-1:0]  o_dbe_tag;

    int checks = 0;
    int errors = 0;

    vec_t  vecs [NVEC];
    beat_t q [$];

    dla_acl_ecc_stream_decoder #(
        .DATA_WIDTH     (DW),
        .ECC_GROUP_SIZE (32),
        .TAG_WIDTH      (TW),
        .COUNTER_WIDTH  (CW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_encoded       (i_encoded),
        .i_tag           (i_tag),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_data          (o_data),
        .o_tag           (o_tag),
        .o_sbe           (o_sbe),
        .o_dbe           (o_dbe),
        .i_clear         (i_clear),
        .o_sbe_count     (o_sbe_count),
        .o_dbe_count     (o_dbe_count),
        .o_dbe_tag_valid (o_dbe_tag_valid),
        .o_dbe_tag       (o_dbe_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference encoder: groups of 32/32/6 data bits -> 39/39/11 code bits.
    function automatic logic [ENC-1:0] encodeWord(input logic [DW-1:0] d);
        logic [ENC-1:0] e;
        logic [63:0]    cw;
        int             ge;
        int             di;
        logic           x;
        e = '0;
        for (int g = 0; g < 3; g++) begin
            ge = (g == 2) ? 11 : 39;
            cw = '0;
            di = 0;
            for (int i = 1; i < ge; i++) begin
                if ((i & (i - 1)) != 0) begin
                    cw[i] = d[g*32 + di];
                    di = di + 1;
                end
            end
            for (int k = 0; k < 6; k++) begin
                if ((1 << k) < ge) begin
                    x = 1'b0;
                    for (int i = 1; i < ge; i++)
                        if (((i >> k) & 1) == 1 && i != (1 << k)) x = x ^ cw[i];
                    cw[1 << k] = x;
                end
            end
            cw[0] = ^cw;
            for (int i = 0; i < ge; i++) e[g*39 + i] = cw[i];
        end
        return e;
    endfunction

    function automatic logic [ENC-1:0] bitMask(input int b);
        return ENC'(1) << b;
    endfunction

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d,
                                 input logic [TW-1:0] t, input logic [ENC-1:0] flips);
        i_valid   = v;
        i_encoded = encodeWord(d) ^ flips;
        i_tag     = t;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int expSbeCnt;
        int expDbeCnt;
        logic expCapValid;
        logic [TW-1:0] expCapTag;
        int sent;
        int recv;
        int budget;
        logic prevStall;
        logic [DW-1:0] prevData;
        logic [TW-1:0] prevTag;
        logic [DW-1:0] rd;
        beat_t b;

        vecs[0] = '{70'h3_0123_4567_89AB_CDEF, 10'h001, '0, 70'h3_0123_4567_89AB_CDEF, 1'b0, 1'b0};
        vecs[1] = '{70'h1_FEDC_BA98_7654_3210, 10'h002, '0, 70'h1_FEDC_BA98_7654_3210, 1'b0, 1'b0};
        vecs[2] = '{70'h2_DEAD_BEEF_CAFE_F00D, 10'h055, bitMask(45), 70'h2_DEAD_BEEF_CAFE_F00D, 1'b1, 1'b0};
        vecs[3] = '{70'h0_1111_2222_3333_4444, 10'h012, bitMask(3) | bitMask(5),
                    70'h0_1111_2222_3333_4447, 1'b0, 1'b1};
        vecs[4] = '{70'h3_AAAA_5555_AAAA_5555, 10'h034, bitMask(79) | bitMask(80),
                    70'h3_AAAA_5555_AAAA_5555, 1'b0, 1'b1};
        vecs[5] = '{70'h1_2345_6789_0ABC_DEF0, 10'h3FF, bitMask(10) | bitMask(79) | bitMask(80),
                    70'h1_2345_6789_0ABC_DEF0, 1'b1, 1'b1};
        vecs[6] = '{70'h0_0000_0000_FFFF_FFFF, 10'h200, bitMask(0), 70'h0_0000_0000_FFFF_FFFF, 1'b1, 1'b0};
        vecs[7] = '{70'h2_0000_0001_8000_0000, 10'h0AA, bitMask(88), 70'h2_0000_0001_8000_0000, 1'b1, 1'b0};
        vecs[8] = '{70'h1_5A5A_A5A5_0F0F_F0F0, 10'h133, bitMask(40) | bitMask(41),
                    70'h1_5A5A_A5A5_0F0F_F0F0, 1'b0, 1'b1};
        vecs[9] = '{70'h3_FFFF_FFFF_FFFF_FFFF, 10'h2C7, '0, 70'h3_FFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};

        reset   = 1'b1;
        i_ready = 1'b1;
        i_clear = 1'b0;
        applyStimulus(1'b0, '0, '0, '0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("reset o_valid", o_valid, 0);
        checkOutput("reset o_ready", o_ready, 1);
        checkOutput("reset o_data", o_data, 0);
        checkOutput("reset o_tag", o_tag, 0);
        checkOutput("reset o_sbe", o_sbe, 0);
        checkOutput("reset o_dbe", o_dbe, 0);
        checkOutput("reset sbe_count", o_sbe_count, 0);
        checkOutput("reset dbe_count", o_dbe_count, 0);
        checkOutput("reset dbe_tag_valid", o_dbe_tag_valid, 0);
        checkOutput("reset dbe_tag", o_dbe_tag, 0);

        // Back-to-back table stream: beat c is seen two negedges after it is driven.
        expSbeCnt   = 0;
        expDbeCnt   = 0;
        expCapValid = 1'b0;
        expCapTag   = '0;
        for (int c = 0; c < NVEC + 2; c++) begin
            @(negedge clock);
            checkOutput($sformatf("vec%0d o_ready", c), o_ready, 1);
            if (c >= 2) begin
                if (vecs[c-2].expSbe && expSbeCnt < 3) expSbeCnt = expSbeCnt + 1;
                if (vecs[c-2].expDbe && expDbeCnt < 3) expDbeCnt = expDbeCnt + 1;
                if (vecs[c-2].expDbe && !expCapValid) begin
                    expCapValid = 1'b1;
                    expCapTag   = vecs[c-2].tag;
                end
                checkOutput($sformatf("vec%0d o_valid", c-2), o_valid, 1);
                checkOutput($sformatf("vec%0d o_data", c-2), o_data, vecs[c-2].expData);
                checkOutput($sformatf("vec%0d o_tag", c-2), o_tag, vecs[c-2].tag);
                checkOutput($sformatf("vec%0d o_sbe", c-2), o_sbe, vecs[c-2].expSbe);
                checkOutput($sformatf("vec%0d o_dbe", c-2), o_dbe, vecs[c-2].expDbe);
                checkOutput($sformatf("vec%0d sbe_count", c-2), o_sbe_count, expSbeCnt);
                checkOutput($sformatf("vec%0d dbe_count", c-2), o_dbe_count, expDbeCnt);
                checkOutput($sformatf("vec%0d dbe_tag_valid", c-2), o_dbe_tag_valid, expCapValid);
                checkOutput($sformatf("vec%0d dbe_tag", c-2), o_dbe_tag, expCapTag);
            end
            if (c < NVEC) applyStimulus(1'b1, vecs[c].data, vecs[c].tag, vecs[c].flips);
            else          applyStimulus(1'b0, '0, '0, '0);
        end

        // Clear coincident with a mixed single+double error beat moving into S2.
        @(negedge clock);
        applyStimulus(1'b1, 70'h0_0F0F_0F0F_0F0F_0F0F, 10'h1C3, bitMask(20) | bitMask(79) | bitMask(80));
        @(negedge clock);
        applyStimulus(1'b0, '0, '0, '0);
        i_clear = 1'b1;
        @(negedge clock);
        i_clear = 1'b0;
        checkOutput("clrmove o_valid", o_valid, 1);
        checkOutput("clrmove o_data", o_data, 70'h0_0F0F_0F0F_0F0F_0F0F);
        checkOutput("clrmove o_sbe", o_sbe, 1);
        checkOutput("clrmove o_dbe", o_dbe, 1);
        checkOutput("clrmove sbe_count", o_sbe_count, 1);
        checkOutput("clrmove dbe_count", o_dbe_count, 1);
        checkOutput("clrmove dbe_tag_valid", o_dbe_tag_valid, 1);
        checkOutput("clrmove dbe_tag", o_dbe_tag, 10'h1C3);

        // Plain clear zeroes everything.
        i_clear = 1'b1;
        @(negedge clock);
        i_clear = 1'b0;
        checkOutput("clear sbe_count", o_sbe_count, 0);
        checkOutput("clear dbe_count", o_dbe_count, 0);
        checkOutput("clear dbe_tag_valid", o_dbe_tag_valid, 0);
        checkOutput("clear dbe_tag", o_dbe_tag, 0);

        // Random valid/ready with clean words against an in-order scoreboard.
        sent      = 0;
        recv      = 0;
        prevStall = 1'b0;
        prevData  = '0;
        prevTag   = '0;
        for (int cyc = 0; cyc < 5000 && recv < NRAND; cyc++) begin
            @(negedge clock);
            if (sent < NRAND && $urandom_range(0, 1) == 1) begin
                rd = DW'({$urandom(), $urandom(), $urandom()});
                applyStimulus(1'b1, rd, TW'($urandom_range(0, 1023)), '0);
            end else begin
                applyStimulus(1'b0, '0, '0, '0);
            end
            i_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (prevStall) begin
                checkOutput("stall o_valid", o_valid, 1);
                checkOutput("stall o_data", o_data, prevData);
                checkOutput("stall o_tag", o_tag, prevTag);
            end
            checkOutput("rand o_ready", o_ready, !(q.size() == 2 && !i_ready));
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    checkOutput("rand unexpected beat", 1, 0);
                end else begin
                    b = q.pop_front();
                    checkOutput("rand o_data", o_data, b.data);
                    checkOutput("rand o_tag", o_tag, b.tag);
                    checkOutput("rand o_sbe", o_sbe, 0);
                    checkOutput("rand o_dbe", o_dbe, 0);
                    recv = recv + 1;
                end
            end
            if (i_valid && o_ready) begin
                q.push_back('{data: rd, tag: i_tag});
                sent = sent + 1;
            end
            prevStall = o_valid && !i_ready;
            prevData  = o_data;
            prevTag   = o_tag;
        end
        checkOutput("rand beats received", recv, NRAND);

        i_valid = 1'b0;
        i_ready = 1'b1;
        budget  = 0;
        while (q.size() > 0 && budget < 10) begin
            @(negedge clock);
            if (o_valid) begin
                b = q.pop_front();
                checkOutput("drain o_data", o_data, b.data);
                checkOutput("drain o_tag", o_tag, b.tag);
            end
            budget = budget + 1;
        end
        checkOutput("drain leftover beats", q.size(), 0);
        checkOutput("rand sbe_count", o_sbe_count, 0);
        checkOutput("rand dbe_count", o_dbe_count, 0);

        // Reset in mid-stream discards in-flight beats asynchronously.
        @(negedge clock);
        applyStimulus(1'b1, 70'h1_0000_0000_0000_0001, 10'h0F0, bitMask(50));
        @(negedge clock);
        applyStimulus(1'b1, 70'h2_2222_2222_2222_2222, 10'h0F1, '0);
        @(negedge clock);
        checkOutput("pre-reset o_valid", o_valid, 1);
        checkOutput("pre-reset o_tag", o_tag, 10'h0F0);
        checkOutput("pre-reset sbe_count", o_sbe_count, 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset o_valid", o_valid, 0);
        checkOutput("midreset o_ready", o_ready, 1);
        checkOutput("midreset o_data", o_data, 0);
        checkOutput("midreset o_tag", o_tag, 0);
        checkOutput("midreset sbe_count", o_sbe_count, 0);
        applyStimulus(1'b0, '0, '0, '0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("post-reset o_valid", o_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
